param_data_memory: RTL and testbench
====================================

PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_W, default 8, SHALL set the address width in bits.
REQ-003 Parameter DEPTH, default 256, SHALL set the number of words; DEPTH <= 2**ADDR_W.
REQ-004 Parameter RD_LAT, default 1, range 1..4, SHALL set the read response latency in cycles.
REQ-005 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 clr_req  input  1  SHALL request a zero-fill of the entire array.
REQ-008 req_valid  input  1  SHALL mark a valid access request.
REQ-009 req_ready  output  1  SHALL indicate that a request can be accepted this cycle.
REQ-010 req_we  input  1  SHALL select write (1) or read (0).
REQ-011 req_addr  input  ADDR_W  SHALL be the word address.
REQ-012 req_wdata  input  DATA_W  SHALL be the write data.
REQ-013 rsp_valid  output  1  SHALL be a one-cycle pulse per accepted read; there is no backpressure.
REQ-014 rsp_rdata  output  DATA_W  SHALL carry the read data, valid while rsp_valid=1.
REQ-015 rsp_err  output  1  SHALL flag an out-of-range address, valid while rsp_valid=1.
REQ-016 busy  output  1  SHALL be high while a zero-fill sweep is in progress.

Function
REQ-017 The FSM SHALL have two states, INIT and READY.
- INIT: sweep zero-fill.
- READY: serve requests.
REQ-018 INIT SHALL write 0 to address clr_ptr each cycle, clr_ptr counting 0..DEPTH-1, then go to READY on the cycle after writing DEPTH-1 (DEPTH cycles total).
REQ-019 In READY, clr_req=1 SHALL move the FSM to INIT with clr_ptr=0 on the next edge.
REQ-020 clr_req SHALL be ignored while the FSM is in INIT.
REQ-021 req_ready SHALL equal (state==READY).
REQ-022 busy SHALL equal (state==INIT).
REQ-023 A request SHALL be accepted when req_valid and req_ready are both 1 at a rising edge.
REQ-024 When clr_req and an accepted request occur in the same cycle, the request SHALL execute first, and INIT SHALL start on the following cycle.
REQ-025 Accepted write with req_addr < DEPTH: mem[req_addr] SHALL take req_wdata at the accepting edge; no response is generated.
REQ-026 Accepted write with req_addr >= DEPTH: the write SHALL be dropped silently; no response is generated.
REQ-027 Accepted read: mem[req_addr] SHALL be sampled at the accepting edge into pipeline stage 1.
REQ-028 The read response SHALL appear after RD_LAT-1 further stages, so rsp_valid rises exactly RD_LAT cycles after the accepting edge.
REQ-029 Accepted read with req_addr >= DEPTH SHALL return rsp_rdata=0 and rsp_err=1.
REQ-030 Accepted read with req_addr < DEPTH SHALL return rsp_err=0.
REQ-031 Back-to-back reads, one per cycle, SHALL yield back-to-back responses in order; throughput is 1 request/cycle.
REQ-032 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-033 Read data SHALL be captured at acceptance, so reads in flight when a clear starts SHALL deliver their pre-clear data.
REQ-034 When rsp_valid=0, rsp_rdata and rsp_err SHALL be 0.
REQ-035 Address and data arithmetic SHALL be unsigned.
REQ-036 clr_ptr SHALL be wide enough to hold DEPTH-1 and SHALL NOT wrap during a sweep.

Reset
REQ-037 rst_n=0 SHALL asynchronously force the following values:
- state=INIT, clr_ptr=0;
- all pipeline valid bits 0;
- rsp_valid=0, rsp_rdata=0, rsp_err=0;
- req_ready=0, busy=1.
REQ-038 After rst_n deasserts, the sweep SHALL run to completion, leaving all DEPTH words 0.
REQ-039 Array contents SHALL NOT be defined before the sweep completes.
REQ-040 Reset asserted mid-sweep or mid-pipeline SHALL discard in-flight responses and restart the sweep from address 0.

Verification
REQ-041 (Defaults, RD_LAT=2) SHALL cover reset release: busy=1 for 256 cycles, then req_ready=1, and reads of addresses 0, 17 and 255 return 0 with rsp_err=0.
REQ-042 SHALL cover write then read: write 0xA5 to addr 0x10 in cycle n, read 0x10 in cycle n+1 -> rsp_valid in cycle n+3 with rsp_rdata=0xA5.
REQ-043 SHALL cover streamed reads: write 0x01/0x02/0x03 to addrs 1/2/3, then read 1,2,3 back-to-back -> three consecutive rsp_valid pulses with data 0x01, 0x02, 0x03.
REQ-044 SHALL cover out-of-range access: DEPTH=200; write 0x77 to addr 210 -> no array change; read addr 210 -> rsp_rdata=0, rsp_err=1.
REQ-045 SHALL cover clear with a read in flight: addr 5 holds 0x3C; read addr 5 with clr_req=1 in the same cycle -> response 0x3C, busy=1 for 256 cycles, and a subsequent read of addr 5 returns 0.
REQ-046 SHALL cover reset mid-sweep: assert rst_n=0 at sweep cycle 100 -> outputs take their reset values immediately, and after release busy=1 for a full 256 cycles.

Source files
------------

// File: rtl/param_data_memory_if.sv
// Request/response bus of the parameterised data memory.
// The master issues requests; the slave (the memory) returns read responses.
interface param_data_memory_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/param_data_memory.sv
// Single-port word memory with a zero-fill sweep after reset or on request,
// and a fixed-latency read pipeline with out-of-range error flagging.
module param_data_memory #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_req,
    output logic busy,
    param_data_memory_if.slave bus
);
    localparam int                PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PTR_W-1:0]  clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              accept_rd;
    logic              addr_ok;
    logic [PTR_W-1:0]  req_idx;
    logic [DATA_W-1:0] rd_word;

    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_err;
    logic [DATA_W-1:0] pipe_data [RD_LAT];

    assign bus.req_ready = (state == READY);
    assign busy          = (state == INIT);

    assign accept    = bus.req_valid && bus.req_ready;
    assign accept_rd = accept && !bus.req_we;
    // Zero-extended compare keeps DEPTH == 2**ADDR_W from truncating to 0.
    assign addr_ok   = ({1'b0, bus.req_addr} < DEPTH_EXT);
    assign req_idx   = bus.req_addr[PTR_W-1:0];
    assign rd_word   = (accept_rd && addr_ok) ? mem[req_idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: assign every always_comb output a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (clr_ptr == LAST_PTR) state_nxt = READY;
            READY:   if (clr_req)             state_nxt = INIT;
            default: state_nxt = INIT;
        endcase
    end

    // The pointer parks at 0 outside INIT, so a new sweep always starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr <= '0;
        end else if (state == INIT) begin
            clr_ptr <= (clr_ptr == LAST_PTR) ? '0 : clr_ptr + PTR_W'(1);
        end
    end

    // NOTE: the array has no reset; the INIT sweep is what defines its contents.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_ptr] <= '0;
        end else if (accept && bus.req_we && addr_ok) begin
            mem[req_idx] <= bus.req_wdata;
        end
    end

    // Data is captured at acceptance, so a clear starting later cannot alter it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            pipe_err <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= accept_rd;
            pipe_err[0]  <= accept_rd && !addr_ok;
            pipe_data[0] <= rd_word;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_err[i]  <= pipe_err[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    // Idle stages carry zeros, so the outputs are already 0 when rsp_valid is low.
    assign bus.rsp_valid = pipe_vld[RD_LAT-1];
    assign bus.rsp_err   = pipe_err[RD_LAT-1];
    assign bus.rsp_rdata = pipe_data[RD_LAT-1];
endmodule

// File: tb/tb_param_data_memory.sv
// Bench for param_data_memory: a 256-word RD_LAT=2 instance and a 200-word
// RD_LAT=3 instance, with a scoreboard checking data, error flag and latency.
module tb_param_data_memory;
    localparam int LAT_A   = 2;
    localparam int LAT_B   = 3;
    localparam int DEPTH_A = 256;
    localparam int DEPTH_B = 200;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cyc;
    } exp_t;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clr_req_a;
    logic clr_req_b;
    logic busy_a;
    logic busy_b;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    exp_t       q_a[$];
    exp_t       q_b[$];
    exp_t       e_a;
    exp_t       e_b;
    logic [7:0] model_a [DEPTH_A];
    logic [7:0] model_b [DEPTH_B];
    vec_t       tab_a [11];
    vec_t       tab_b [8];

    param_data_memory_if #(.DATA_W(8), .ADDR_W(8)) if_a ();
    param_data_memory_if #(.DATA_W(8), .ADDR_W(8)) if_b ();

    param_data_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH_A), .RD_LAT(LAT_A)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req_a),
        .busy    (busy_a),
        .bus     (if_a.slave)
    );

    param_data_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH_B), .RD_LAT(LAT_B)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req_b),
        .busy    (busy_b),
        .bus     (if_b.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Responses are compared at the falling edge, away from the register updates.
    always @(negedge clk) begin
        if (mon_en) begin
            if (if_a.rsp_valid === 1'b1) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_rsp", if_a.rsp_valid, 1'b0);
                end else begin
                    e_a = q_a.pop_front();
                    check("a_rdata", if_a.rsp_rdata, e_a.data);
                    check("a_err", if_a.rsp_err, e_a.err);
                    check("a_latency", cyc, e_a.cyc);
                end
            end else begin
                check("a_idle_rsp", {if_a.rsp_valid, if_a.rsp_err, if_a.rsp_rdata}, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (if_b.rsp_valid === 1'b1) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_rsp", if_b.rsp_valid, 1'b0);
                end else begin
                    e_b = q_b.pop_front();
                    check("b_rdata", if_b.rsp_rdata, e_b.data);
                    check("b_err", if_b.rsp_err, e_b.err);
                    check("b_latency", cyc, e_b.cyc);
                end
            end else begin
                check("b_idle_rsp", {if_b.rsp_valid, if_b.rsp_err, if_b.rsp_rdata}, 0);
            end
        end
    end

    // Called at a falling edge; drives one request for one cycle.
    task automatic issue(input bit sel, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_d,
                         input logic exp_e, input bit track);
        if (!sel) begin
            check("a_ready", if_a.req_ready, 1'b1);
            if_a.req_valid = 1'b1;
            if_a.req_we    = we;
            if_a.req_addr  = addr;
            if_a.req_wdata = wdata;
            if (!we && track) q_a.push_back('{data: exp_d, err: exp_e, cyc: cyc + LAT_A});
        end else begin
            check("b_ready", if_b.req_ready, 1'b1);
            if_b.req_valid = 1'b1;
            if_b.req_we    = we;
            if_b.req_addr  = addr;
            if_b.req_wdata = wdata;
            if (!we && track) q_b.push_back('{data: exp_d, err: exp_e, cyc: cyc + LAT_B});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        if_a.req_valid = 1'b0;
        if_b.req_valid = 1'b0;
    endtask

    // Counts falling edges with busy high; optionally holds clr_req and a read
    // request during the first hold cycles to show both are ignored in INIT.
    task automatic count_busy(input bit sel, input int hold, output int n);
        n = 0;
        while (((sel ? busy_b : busy_a) === 1'b1) && n < 1000) begin
            if (!sel) begin
                check("a_ready_low_in_init", if_a.req_ready, 1'b0);
                if (hold > 0) begin
                    clr_req_a      = (n < hold);
                    if_a.req_valid = (n < hold);
                    if_a.req_we    = 1'b0;
                    if_a.req_addr  = 8'd5;
                end
            end
            n++;
            @(negedge clk);
        end
        if (!sel) begin
            clr_req_a      = 1'b0;
            if_a.req_valid = 1'b0;
        end
    endtask

    task automatic release_and_count(input string tag);
        int na;
        int nb;
        rst_n = 1'b1;
        fork
            count_busy(1'b0, 0, na);
            count_busy(1'b1, 0, nb);
        join
        check({tag, "_busy_cycles_a"}, na, DEPTH_A);
        check({tag, "_busy_cycles_b"}, nb, DEPTH_B);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;

        tab_a[0]  = '{1'b0, 8'd0,   8'h00, 8'h00, 1'b0};
        tab_a[1]  = '{1'b0, 8'd17,  8'h00, 8'h00, 1'b0};
        tab_a[2]  = '{1'b0, 8'd255, 8'h00, 8'h00, 1'b0};
        tab_a[3]  = '{1'b1, 8'h10,  8'hA5, 8'h00, 1'b0};
        tab_a[4]  = '{1'b0, 8'h10,  8'h00, 8'hA5, 1'b0};
        tab_a[5]  = '{1'b1, 8'd1,   8'h01, 8'h00, 1'b0};
        tab_a[6]  = '{1'b1, 8'd2,   8'h02, 8'h00, 1'b0};
        tab_a[7]  = '{1'b1, 8'd3,   8'h03, 8'h00, 1'b0};
        tab_a[8]  = '{1'b0, 8'd1,   8'h00, 8'h01, 1'b0};
        tab_a[9]  = '{1'b0, 8'd2,   8'h00, 8'h02, 1'b0};
        tab_a[10] = '{1'b0, 8'd3,   8'h00, 8'h03, 1'b0};

        tab_b[0]  = '{1'b1, 8'd210, 8'h77, 8'h00, 1'b0};
        tab_b[1]  = '{1'b0, 8'd210, 8'h00, 8'h00, 1'b1};
        tab_b[2]  = '{1'b0, 8'd10,  8'h00, 8'h00, 1'b0};
        tab_b[3]  = '{1'b0, 8'd82,  8'h00, 8'h00, 1'b0};
        tab_b[4]  = '{1'b0, 8'd199, 8'h00, 8'h00, 1'b0};
        tab_b[5]  = '{1'b1, 8'd199, 8'h11, 8'h00, 1'b0};
        tab_b[6]  = '{1'b0, 8'd199, 8'h00, 8'h11, 1'b0};
        tab_b[7]  = '{1'b0, 8'd200, 8'h00, 8'h00, 1'b1};

        rst_n = 1'b0;
        clr_req_a = 1'b0;
        clr_req_b = 1'b0;
        if_a.req_valid = 1'b0; if_a.req_we = 1'b0; if_a.req_addr = '0; if_a.req_wdata = '0;
        if_b.req_valid = 1'b0; if_b.req_we = 1'b0; if_b.req_addr = '0; if_b.req_wdata = '0;

        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_busy_a", busy_a, 1'b1);
        check("rst_ready_a", if_a.req_ready, 1'b0);
        check("rst_busy_b", busy_b, 1'b1);
        check("rst_ready_b", if_b.req_ready, 1'b0);
        @(negedge clk);
        release_and_count("init");

        // Vector tables, one request per cycle.
        for (int i = 0; i < 11; i++)
            issue(1'b0, tab_a[i].we, tab_a[i].addr, tab_a[i].wdata, tab_a[i].exp_data, tab_a[i].exp_err, 1'b1);
        idle();
        for (int i = 0; i < 8; i++)
            issue(1'b1, tab_b[i].we, tab_b[i].addr, tab_b[i].wdata, tab_b[i].exp_data, tab_b[i].exp_err, 1'b1);
        idle();
        repeat (5) @(negedge clk);

        // Clear issued together with a read: the read still returns pre-clear data.
        issue(1'b0, 1'b1, 8'd5, 8'h3C, 8'h00, 1'b0, 1'b1);
        clr_req_a = 1'b1;
        issue(1'b0, 1'b0, 8'd5, 8'h00, 8'h3C, 1'b0, 1'b1);
        count_busy(1'b0, 10, n);
        check("clr_busy_cycles", n, DEPTH_A);
        issue(1'b0, 1'b0, 8'd5, 8'h00, 8'h00, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b1);
        idle();
        repeat (4) @(negedge clk);

        // Reset while one response is showing and another sits in stage 1.
        issue(1'b0, 1'b1, 8'd3, 8'h5A, 8'h00, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 8'd3, 8'h00, 8'h5A, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 8'd3, 8'h00, 8'h00, 1'b0, 1'b0);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("pipe_rst_valid", if_a.rsp_valid, 1'b0);
        check("pipe_rst_rdata", if_a.rsp_rdata, 8'h00);
        check("pipe_rst_busy", busy_a, 1'b1);
        check("pipe_rst_ready", if_a.req_ready, 1'b0);
        check("pipe_rst_queue", q_a.size(), 0);
        q_a.delete();
        q_b.delete();
        repeat (2) @(negedge clk);
        release_and_count("pipe_rst");

        // Reset 100 cycles into a requested sweep.
        clr_req_a = 1'b1;
        @(negedge clk);
        clr_req_a = 1'b0;
        repeat (99) @(negedge clk);
        check("sweep_mid_busy", busy_a, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("sweep_rst_busy_a", busy_a, 1'b1);
        check("sweep_rst_ready_a", if_a.req_ready, 1'b0);
        check("sweep_rst_ready_b", if_b.req_ready, 1'b0);
        check("sweep_rst_rsp", {if_a.rsp_valid, if_a.rsp_err, if_a.rsp_rdata}, 0);
        repeat (2) @(negedge clk);
        release_and_count("sweep_rst");

        // Mixed random traffic against a reference array.
        for (int i = 0; i < DEPTH_A; i++) model_a[i] = 8'h00;
        for (int i = 0; i < DEPTH_B; i++) model_b[i] = 8'h00;
        for (int i = 0; i < 80; i++) begin
            we   = 1'($urandom_range(0, 1));
            addr = 8'($urandom_range(0, 15));
            data = 8'($urandom_range(0, 255));
            if (we) model_a[addr] = data;
            issue(1'b0, we, addr, data, model_a[addr], 1'b0, 1'b1);
        end
        idle();
        for (int i = 0; i < 80; i++) begin
            we   = 1'($urandom_range(0, 1));
            addr = 8'($urandom_range(190, 215));
            data = 8'($urandom_range(0, 255));
            if (we && addr < DEPTH_B) model_b[addr] = data;
            issue(1'b1, we, addr, data, (addr < DEPTH_B) ? model_b[addr] : 8'h00,
                  (addr >= DEPTH_B), 1'b1);
        end
        idle();
        repeat (8) @(negedge clk);
        check("a_missing_rsp", q_a.size(), 0);
        check("b_missing_rsp", q_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
